// File: rtl/spi_burst_master.sv
// spi_burst_master: multi-byte SPI burst engine with byte-level tx_ready/rx_valid handshake,
// programmable SCK divider and SPI mode. Define SPI_LOOPBACK_EN to feed sdo back into the receiver.
module spi_burst_master #(
    parameter int CLK_DIV = 6,
    parameter int LEN_W   = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic             clk12MHz,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             sck,
    output logic             sdo,
    output logic             csb,
    input  logic             sdi
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ZERO  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] ZERO     = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       div_r;
    logic [3:0]       half_r;
    logic [LEN_W-1:0] byte_cnt_r;
    logic [7:0]       tx_sh_r;
    logic [6:0]       rx_sh_r;
    logic             sdi_src;

    logic tick_s;
    logic edge_s;
    logic sample_s;
    logic shift_s;
    logic last_sample_s;
    logic byte_end_s;
    logic last_byte_s;

`ifdef SPI_LOOPBACK_EN
    logic unused_sdi;
    assign unused_sdi = sdi;
    assign sdi_src    = sdo;
`else
    assign sdi_src = sdi;
`endif

    // SCK edge strobes; half_r[0]=0 marks the leading edge, the 16th half-period closes a byte.
    always_comb begin
        tick_s        = (div_r == DIV_LAST);
        edge_s        = (state_r == ST_SHIFT) && tick_s;
        sample_s      = CPHA ? (edge_s && half_r[0]) : (edge_s && !half_r[0]);
        shift_s       = CPHA ? (edge_s && !half_r[0]) : (edge_s && half_r[0]);
        last_sample_s = sample_s && (half_r == (CPHA ? 4'd15 : 4'd14));
        byte_end_s    = edge_s && (half_r == 4'd15);
        last_byte_s   = CPHA ? (byte_cnt_r <= ONE) : (byte_cnt_r == ZERO);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = start ? ((len != ZERO) ? ST_SETUP : ST_ZERO) : ST_IDLE;
            ST_SETUP: state_s = tick_s ? ST_SHIFT : ST_SETUP;
            ST_SHIFT: state_s = (byte_end_s && last_byte_s) ? ST_HOLD : ST_SHIFT;
            ST_HOLD:  state_s = tick_s ? ST_DONE : ST_HOLD;
            ST_ZERO:  state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk12MHz) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Half-period divider and half-period index within the current byte.
    always_ff @(posedge clk12MHz) begin
        if (!rst_n) begin
            div_r  <= 8'd0;
            half_r <= 4'd0;
        end else begin
            if ((state_r inside {ST_SETUP, ST_SHIFT, ST_HOLD}) && !tick_s) begin
                div_r <= div_r + 8'd1;
            end else begin
                div_r <= 8'd0;
            end
            if (state_r != ST_SHIFT) begin
                half_r <= 4'd0;
            end else if (tick_s) begin
                half_r <= half_r + 4'd1;
            end
        end
    end

    // Pins, shift registers, byte counter and handshake strobes.
    always_ff @(posedge clk12MHz) begin
        if (!rst_n) begin
            csb        <= 1'b1;
            sck        <= CPOL;
            sdo        <= 1'b0;
            tx_ready   <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            tx_sh_r    <= 8'h00;
            rx_sh_r    <= 7'h00;
            byte_cnt_r <= ZERO;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            csb      <= !(state_s inside {ST_SETUP, ST_SHIFT, ST_HOLD});
            busy     <= (state_s inside {ST_SETUP, ST_SHIFT, ST_HOLD, ST_ZERO});
            done     <= (state_s == ST_DONE);

            if (state_r != ST_SHIFT) begin
                sck <= CPOL;
            end else if (tick_s) begin
                sck <= ~sck;
            end

            if ((state_r == ST_IDLE) && start && (len != ZERO)) begin
                tx_sh_r    <= tx_data;
                tx_ready   <= 1'b1;
                byte_cnt_r <= len;
                sdo        <= CPHA ? 1'b0 : tx_data[7];
            end

            // CPHA=0 keeps the current bit on sdo; at byte end the freshly reloaded MSB goes out unshifted.
            if (shift_s) begin
                if (CPHA) begin
                    sdo     <= tx_sh_r[7];
                    tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                end else if (byte_end_s) begin
                    sdo <= tx_sh_r[7];
                end else begin
                    sdo     <= tx_sh_r[6];
                    tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                end
            end

            if (sample_s) begin
                rx_sh_r <= {rx_sh_r[5:0], sdi_src};
            end

            if (last_sample_s) begin
                rx_data  <= {rx_sh_r, sdi_src};
                rx_valid <= 1'b1;
                if (byte_cnt_r != ZERO) begin
                    byte_cnt_r <= byte_cnt_r - ONE;
                end
                if (byte_cnt_r > ONE) begin
                    tx_sh_r  <= tx_data;
                    tx_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: mode-0 (CLK_DIV=2) and mode-3 (CLK_DIV=3) instances with SPI slave models
// and an rx scoreboard; expectations follow SPI_LOOPBACK_EN when it is defined.
module tb_spi_burst_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [3:0] len_a, len_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_ready_a, tx_ready_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic       sck_a, sck_b, sdo_a, sdo_b, csb_a, csb_b;
    logic       sdi_a, sdi_b;

    int errors = 0;
    int checks = 0;

    spi_burst_master #(.CLK_DIV(2), .LEN_W(4), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
        .clk12MHz(clk), .rst_n(rst_n), .start(start_a), .len(len_a), .tx_data(tx_data_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
        .done(done_a), .sck(sck_a), .sdo(sdo_a), .csb(csb_a), .sdi(sdi_a)
    );

    spi_burst_master #(.CLK_DIV(3), .LEN_W(4), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
        .clk12MHz(clk), .rst_n(rst_n), .start(start_b), .len(len_b), .tx_data(tx_data_b),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .done(done_b), .sck(sck_b), .sdo(sdo_b), .csb(csb_b), .sdi(sdi_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sbit(input logic [31:0] v, input int n);
        return (n >= 0 && n < 32) ? v[31-n] : 1'b0;
    endfunction

    // Slave models: response stream MSB first, MOSI captured on rising SCK (sample edge in both modes).
    logic [31:0] resp_a = 32'h0, resp_b = 32'h0;
    logic [31:0] mosi_a = 32'h0, mosi_b = 32'h0;
    int          rise_a = 0, rise_b = 0, nbit_a = 0, nbit_b = 0;
    logic        pcsb_a = 1'b1, psck_a = 1'b0, pcsb_b = 1'b1, psck_b = 1'b1;

    always @(sck_a, csb_a) begin
        if (pcsb_a === 1'b1 && csb_a === 1'b0) begin
            nbit_a = 0; rise_a = 0; mosi_a = 32'h0;
            sdi_a  = sbit(resp_a, 0);
        end else if (csb_a === 1'b0 && psck_a === 1'b0 && sck_a === 1'b1) begin
            mosi_a = {mosi_a[30:0], sdo_a}; rise_a++;
        end else if (csb_a === 1'b0 && psck_a === 1'b1 && sck_a === 1'b0) begin
            nbit_a++;
            sdi_a = sbit(resp_a, nbit_a);
        end
        pcsb_a = csb_a; psck_a = sck_a;
    end

    always @(sck_b, csb_b) begin
        if (pcsb_b === 1'b1 && csb_b === 1'b0) begin
            nbit_b = 0; rise_b = 0; mosi_b = 32'h0; sdi_b = 1'b0;
        end else if (csb_b === 1'b0 && psck_b === 1'b0 && sck_b === 1'b1) begin
            mosi_b = {mosi_b[30:0], sdo_b}; rise_b++;
        end else if (csb_b === 1'b0 && psck_b === 1'b1 && sck_b === 1'b0) begin
            sdi_b = sbit(resp_b, nbit_b);
            nbit_b++;
        end
        pcsb_b = csb_b; psck_b = sck_b;
    end

    // Scoreboards: expected rx bytes are queued when a burst is launched.
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] e_a, e_b;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid_a === 1'b1) begin
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                check("rx_a", 32'(rx_data_a), 32'(e_a));
            end else begin
                check("rx_a_unexpected", 32'(q_a.size()), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid_b === 1'b1) begin
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                check("rx_b", 32'(rx_data_b), 32'(e_b));
            end else begin
                check("rx_b_unexpected", 32'(q_b.size()), 32'd1);
            end
        end
    end

    int   sel = 0;
    logic o_csb, o_busy, o_done, o_tx_ready, o_rx_valid;
    assign o_csb      = (sel == 0) ? csb_a      : csb_b;
    assign o_busy     = (sel == 0) ? busy_a     : busy_b;
    assign o_done     = (sel == 0) ? done_a     : done_b;
    assign o_tx_ready = (sel == 0) ? tx_ready_a : tx_ready_b;
    assign o_rx_valid = (sel == 0) ? rx_valid_a : rx_valid_b;

    int r_cycles, r_fall, r_ntr, r_nrx, r_gap, r_done, r_busy1;

    task automatic set_start(input int s, input logic st, input int ln);
        if (s == 0) begin start_a = st; len_a = 4'(ln); end
        else begin start_b = st; len_b = 4'(ln); end
    endtask

    task automatic set_tx(input int s, input logic [7:0] d);
        if (s == 0) tx_data_a = d;
        else tx_data_b = d;
    endtask

    // Launch a burst and follow it until done or until the cycle budget runs out.
    task automatic run_burst(input int s, input int n_bytes, input logic [31:0] tx_v,
                             input logic [31:0] resp_v, input logic [31:0] exp_v,
                             input int glitch, input int budget);
        int n;
        sel = s;
        if (s == 0) resp_a = resp_v;
        else resp_b = resp_v;
        for (int i = 0; i < n_bytes; i++) begin
            if (s == 0) q_a.push_back(exp_v[31-8*i -: 8]);
            else q_b.push_back(exp_v[31-8*i -: 8]);
        end
        set_tx(s, tx_v[31:24]);
        set_start(s, 1'b1, n_bytes);
        @(posedge clk);
        #1;
        set_start(s, 1'b0, n_bytes);
        n = 0; r_fall = -1; r_ntr = 0; r_nrx = 0; r_gap = 0; r_done = 0; r_busy1 = 0;
        while (n < budget && r_done == 0) begin
            @(negedge clk);
            n++;
            if (n == 1) r_busy1 = int'(o_busy);
            if (o_csb === 1'b0 && r_fall < 0) r_fall = n;
            if (o_csb === 1'b1 && r_fall >= 0 && o_done !== 1'b1) r_gap = 1;
            if (o_tx_ready === 1'b1) begin
                r_ntr++;
                if (r_ntr < 4) set_tx(s, tx_v[31-8*r_ntr -: 8]);
            end
            if (o_rx_valid === 1'b1) r_nrx++;
            if (n == glitch) set_start(s, 1'b1, 5);
            else set_start(s, 1'b0, n_bytes);
            if (o_done === 1'b1) r_done = 1;
        end
        set_start(s, 1'b0, n_bytes);
        r_cycles = (r_fall >= 0) ? (n - r_fall) : n;
        check("done_seen", 32'(r_done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    int         done_cnt;
    logic [7:0] lb0, lb1;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; len_a = 4'd0; len_b = 4'd0;
        tx_data_a = 8'h00; tx_data_b = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_csb_a", 32'(csb_a), 32'd1);
        check("rst_sck_a", 32'(sck_a), 32'd0);
        check("rst_sdo_a", 32'(sdo_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_txr_a", 32'(tx_ready_a), 32'd0);
        check("rst_rxv_a", 32'(rx_valid_a), 32'd0);
        check("rst_rxd_a", 32'(rx_data_a), 32'd0);
        check("rst_csb_b", 32'(csb_b), 32'd1);
        check("rst_sck_b", 32'(sck_b), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1-byte mode-0 write, sdi held high.
        run_burst(0, 1, 32'hA500_0000, 32'hFFFF_FFFF, 32'hFF00_0000, 0, 200);
        check("t1_csb_to_done", 32'(r_cycles), 32'd36);
        check("t1_sck_rises", 32'(rise_a), 32'd8);
        check("t1_mosi", mosi_a, 32'h0000_00A5);
        check("t1_tx_ready", 32'(r_ntr), 32'd1);
        check("t1_rx_valid", 32'(r_nrx), 32'd1);
        check("t1_busy", 32'(r_busy1), 32'd1);

        // BMP280 ID read with a start pulse injected mid-burst.
        run_burst(0, 3, 32'hD000_0000, 32'h0058_5800, 32'h0058_5800, 20, 300);
        check("t2_csb_to_done", 32'(r_cycles), 32'd100);
        check("t2_sck_rises", 32'(rise_a), 32'd24);
        check("t2_mosi", mosi_a, 32'h00D0_0000);
        check("t2_tx_ready", 32'(r_ntr), 32'd3);
        check("t2_rx_valid", 32'(r_nrx), 32'd3);
        check("t2_csb_gap", 32'(r_gap), 32'd0);
        check("t2_idle_after", 32'(busy_a), 32'd0);

        // Mode 3 on the second instance.
        check("t3_sck_idle_pre", 32'(sck_b), 32'd1);
        run_burst(1, 1, 32'h3C00_0000, 32'hA600_0000, 32'hA600_0000, 0, 200);
        check("t3_csb_to_done", 32'(r_cycles), 32'd54);
        check("t3_sck_rises", 32'(rise_b), 32'd8);
        check("t3_mosi", mosi_b, 32'h0000_003C);
        check("t3_rx_valid", 32'(r_nrx), 32'd1);
        check("t3_sck_idle_post", 32'(sck_b), 32'd1);

        // Zero-length burst.
        run_burst(0, 0, 32'h7700_0000, 32'h0, 32'h0, 0, 20);
        check("t4_done_delay", 32'(r_cycles), 32'd2);
        check("t4_csb_fell", 32'(r_fall), 32'hFFFF_FFFF);
        check("t4_busy", 32'(r_busy1), 32'd1);
        check("t4_no_txr", 32'(r_ntr), 32'd0);

        // Two bytes with sdi held low; loopback builds see the tx bytes instead.
`ifdef SPI_LOOPBACK_EN
        lb0 = 8'h12; lb1 = 8'h34;
`else
        lb0 = 8'h00; lb1 = 8'h00;
`endif
        run_burst(0, 2, 32'h1234_0000, 32'h0, {lb0, lb1, 16'h0}, 0, 200);
        check("t5_mosi", mosi_a, 32'h0000_1234);
        check("t5_rx_valid", 32'(r_nrx), 32'd2);

        // Reset held three cycles mid-burst.
        sel = 0;
        resp_a = 32'hFFFF_FFFF;
        tx_data_a = 8'hA5; len_a = 4'd2; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_csb_low", 32'(csb_a), 32'd0);
        rst_n = 1'b0;
        done_cnt = 0;
        @(negedge clk);
        check("t6_csb", 32'(csb_a), 32'd1);
        check("t6_sck", 32'(sck_a), 32'd0);
        check("t6_busy", 32'(busy_a), 32'd0);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) rst_n = 1'b1;
            if (done_a === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("t6_no_done", 32'(done_cnt), 32'd0);

        // Recovery burst after the abort.
        run_burst(0, 1, 32'h8100_0000, 32'h5A00_0000, 32'h5A00_0000, 0, 200);
        check("t7_mosi", mosi_a, 32'h0000_0081);
        check("t7_csb_to_done", 32'(r_cycles), 32'd36);

        repeat (3) @(negedge clk);
        check("sb_a_empty", 32'(q_a.size()), 32'd0);
        check("sb_b_empty", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
